// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline write-back stream has priority over the
// long-latency unit stream. A one-entry buffer holds a losing LU result, and a starvation limit
// eventually forces that result out.
module wb_port_arbiter #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned REG_ADD_WIDTH = 5,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     PIPE_VALID,
  input  logic [REG_ADD_WIDTH-1:0] PIPE_RD,
  input  logic [DATA_WIDTH-1:0]    PIPE_DATA,
  output logic                     PIPE_STALL,
  input  logic                     LU_VALID,
  input  logic [REG_ADD_WIDTH-1:0] LU_RD,
  input  logic [DATA_WIDTH-1:0]    LU_DATA,
  output logic                     LU_READY,
  output logic                     WB_SELECT,
  output logic                     RF_WRITE_EN,
  output logic [REG_ADD_WIDTH-1:0] RF_WRITE_ADD,
  output logic [DATA_WIDTH-1:0]    RF_WRITE_DATA,
  output logic                     BUSY
);

  localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StPending, StForce} state_e;

  state_e                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [REG_ADD_WIDTH-1:0] buf_rd_q, buf_rd_d;
  logic [DATA_WIDTH-1:0]    buf_data_q, buf_data_d;

  logic                     wb_sel_q;
  logic                     rf_we_q;
  logic [REG_ADD_WIDTH-1:0] rf_add_q;
  logic [DATA_WIDTH-1:0]    rf_data_q;

  logic                     grant;
  logic                     grant_sel;
  logic [REG_ADD_WIDTH-1:0] grant_rd;
  logic [DATA_WIDTH-1:0]    grant_data;
  logic [3:0]               cnt_inc;
  logic                     pipe_hits_buf;
  logic                     pipe_hits_lu;

  assign cnt_inc       = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  // A younger pipeline write to the same (non-zero) register makes the older LU result dead.
  assign pipe_hits_buf = (PIPE_RD == buf_rd_q) && (buf_rd_q != '0);
  assign pipe_hits_lu  = (PIPE_RD == LU_RD) && (LU_RD != '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    grant      = 1'b0;
    grant_sel  = 1'b0;
    grant_rd   = '0;
    grant_data = '0;

    unique case (state_q)
      StIdle: begin
        if (PIPE_VALID) begin
          grant      = 1'b1;
          grant_rd   = PIPE_RD;
          grant_data = PIPE_DATA;
          if (LU_VALID && !pipe_hits_lu) begin
            buf_rd_d   = LU_RD;
            buf_data_d = LU_DATA;
            cnt_d      = 4'd0;
            state_d    = StPending;
          end
        end else if (LU_VALID) begin
          grant      = 1'b1;
          grant_sel  = 1'b1;
          grant_rd   = LU_RD;
          grant_data = LU_DATA;
        end
      end
      StPending: begin
        if (!PIPE_VALID) begin
          grant      = 1'b1;
          grant_sel  = 1'b1;
          grant_rd   = buf_rd_q;
          grant_data = buf_data_q;
          cnt_d      = 4'd0;
          state_d    = StIdle;
        end else begin
          grant      = 1'b1;
          grant_rd   = PIPE_RD;
          grant_data = PIPE_DATA;
          if (pipe_hits_buf) begin
            cnt_d   = 4'd0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= StarveLimit) begin
              state_d = StForce;
            end
          end
        end
      end
      StForce: begin
        grant      = 1'b1;
        grant_sel  = 1'b1;
        grant_rd   = buf_rd_q;
        grant_data = buf_data_q;
        cnt_d      = 4'd0;
        state_d    = StIdle;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      buf_rd_q   <= '0;
      buf_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_rd_q   <= buf_rd_d;
      buf_data_q <= buf_data_d;
    end
  end

  // Address, data and select only move on a grant; x0 grants are consumed but never enabled.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wb_sel_q  <= 1'b0;
      rf_we_q   <= 1'b0;
      rf_add_q  <= '0;
      rf_data_q <= '0;
    end else begin
      rf_we_q <= grant && (grant_rd != '0);
      if (grant) begin
        wb_sel_q  <= grant_sel;
        rf_add_q  <= grant_rd;
        rf_data_q <= grant_data;
      end
    end
  end

  assign PIPE_STALL    = (state_q == StForce) && PIPE_VALID;
  assign LU_READY      = (state_q == StIdle);
  assign BUSY          = (state_q != StIdle);
  assign WB_SELECT     = wb_sel_q;
  assign RF_WRITE_EN   = rf_we_q;
  assign RF_WRITE_ADD  = rf_add_q;
  assign RF_WRITE_DATA = rf_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic, checked against a
// transaction-level model of the one-entry buffer and its loss count.
module tb_wb_port_arbiter;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned LIM = 4;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          PIPE_VALID;
  logic [AW-1:0] PIPE_RD;
  logic [DW-1:0] PIPE_DATA;
  logic          PIPE_STALL;
  logic          LU_VALID;
  logic [AW-1:0] LU_RD;
  logic [DW-1:0] LU_DATA;
  logic          LU_READY;
  logic          WB_SELECT;
  logic          RF_WRITE_EN;
  logic [AW-1:0] RF_WRITE_ADD;
  logic [DW-1:0] RF_WRITE_DATA;
  logic          BUSY;

  always #5 CLK = ~CLK;

  wb_port_arbiter #(
    .DATA_WIDTH   (DW),
    .REG_ADD_WIDTH(AW),
    .STARVE_LIMIT (LIM)
  ) u_dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .PIPE_VALID   (PIPE_VALID),
    .PIPE_RD      (PIPE_RD),
    .PIPE_DATA    (PIPE_DATA),
    .PIPE_STALL   (PIPE_STALL),
    .LU_VALID     (LU_VALID),
    .LU_RD        (LU_RD),
    .LU_DATA      (LU_DATA),
    .LU_READY     (LU_READY),
    .WB_SELECT    (WB_SELECT),
    .RF_WRITE_EN  (RF_WRITE_EN),
    .RF_WRITE_ADD (RF_WRITE_ADD),
    .RF_WRITE_DATA(RF_WRITE_DATA),
    .BUSY         (BUSY)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: a buffer that is either empty or holds one LU result, plus the number of
  // arbitration rounds that result has lost.
  bit            m_full;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_data;
  int            m_losses;

  // Expected registered write for the previous cycle.
  bit            exp_chk;
  bit            e_we;
  bit            e_sel;
  logic [AW-1:0] e_add;
  logic [DW-1:0] e_data;
  bit            hold_known;

  // Handshake obligations carried into the next cycle.
  bit            pipe_hold;
  bit            lu_hold;
  bit            s_pv;
  logic [AW-1:0] s_prd;
  logic [DW-1:0] s_pd;
  bit            s_lv;
  logic [AW-1:0] s_lrd;
  logic [DW-1:0] s_ld;

  task automatic model_write(input bit sel, input logic [AW-1:0] rd, input logic [DW-1:0] data);
    e_we = (rd != 0);
    if (rd != 0) begin
      e_sel      = sel;
      e_add      = rd;
      e_data     = data;
      hold_known = 1'b1;
    end else begin
      hold_known = 1'b0;
    end
  endtask

  task automatic check_out();
    check_eq("rf_write_en", RF_WRITE_EN, e_we);
    if (e_we) check_eq("wb_select", WB_SELECT, e_sel);
    if (e_we || hold_known) begin
      check_eq("rf_write_add", RF_WRITE_ADD, e_add);
      check_eq("rf_write_data", RF_WRITE_DATA, e_data);
    end
  endtask

  task automatic model_reset();
    m_full     = 1'b0;
    m_losses   = 0;
    e_we       = 1'b0;
    e_add      = '0;
    e_data     = '0;
    hold_known = 1'b1;
    pipe_hold  = 1'b0;
    lu_hold    = 1'b0;
  endtask

  task automatic step(input bit pv, input logic [AW-1:0] prd, input logic [DW-1:0] pd,
                      input bit lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld);
    bit forced;
    @(negedge CLK);
    if (exp_chk) check_out();
    PIPE_VALID = pv;
    PIPE_RD    = prd;
    PIPE_DATA  = pd;
    LU_VALID   = lv;
    LU_RD      = lrd;
    LU_DATA    = ld;
    s_pv = pv; s_prd = prd; s_pd = pd;
    s_lv = lv; s_lrd = lrd; s_ld = ld;
    #1;
    forced = m_full && (m_losses >= LIM);
    check_eq("pipe_stall", PIPE_STALL, forced && pv);
    check_eq("lu_ready", LU_READY, !m_full);
    check_eq("busy", BUSY, m_full);
    pipe_hold = forced && pv;
    lu_hold   = lv && m_full;
    e_we      = 1'b0;
    if (m_full && (forced || !pv)) begin
      model_write(1'b1, m_rd, m_data);
      m_full = 1'b0;
    end else if (m_full) begin
      model_write(1'b0, prd, pd);
      if (prd == m_rd && prd != 0) m_full = 1'b0;
      else m_losses++;
    end else if (pv) begin
      model_write(1'b0, prd, pd);
      if (lv && !(lrd == prd && lrd != 0)) begin
        m_full   = 1'b1;
        m_rd     = lrd;
        m_data   = ld;
        m_losses = 0;
      end
    end else if (lv) begin
      model_write(1'b1, lrd, ld);
    end
    exp_chk = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    RST_N      = 1'b0;
    PIPE_VALID = 1'b0;
    PIPE_RD    = '0;
    PIPE_DATA  = '0;
    LU_VALID   = 1'b0;
    LU_RD      = '0;
    LU_DATA    = '0;
    exp_chk    = 1'b0;
    model_reset();
    #2;
    check_eq("rst_rf_we", RF_WRITE_EN, 1'b0);
    check_eq("rst_rf_add", RF_WRITE_ADD, '0);
    check_eq("rst_rf_data", RF_WRITE_DATA, '0);
    check_eq("rst_wb_sel", WB_SELECT, 1'b0);
    check_eq("rst_busy", BUSY, 1'b0);
    check_eq("rst_stall", PIPE_STALL, 1'b0);
    check_eq("rst_lu_ready", LU_READY, 1'b1);
    @(negedge CLK);
    RST_N = 1'b1;
    idle(2);

    // LU bypass while the pipeline is idle.
    step(1'b0, '0, '0, 1'b1, 5'd3, 32'hDEADBEEF);
    idle(1);

    // Simultaneous producers, then the buffered result drains.
    step(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    idle(2);

    // Starvation: capture, four pipeline wins, one forced drain with a stall, then retry.
    step(1'b1, 5'd1, 32'h101, 1'b1, 5'd9, 32'h999);
    for (int i = 2; i <= 5; i++) step(1'b1, 5'(i), 32'(i) * 32'h101, 1'b0, '0, '0);
    step(1'b1, 5'd6, 32'h606, 1'b0, '0, '0);
    check_eq("starve_stall_seen", pipe_hold, 1'b1);
    step(1'b1, 5'd6, 32'h606, 1'b0, '0, '0);
    idle(1);

    // Same-register kill in PENDING, and on the capture cycle.
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd5, 32'hAA);
    step(1'b1, 5'd5, 32'hBB, 1'b0, '0, '0);
    idle(2);
    step(1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 32'h45);
    idle(2);

    // Writes to x0 from both sources.
    step(1'b0, '0, '0, 1'b1, 5'd0, 32'h123);
    step(1'b1, 5'd0, 32'h55, 1'b0, '0, '0);
    idle(2);

    // Asynchronous reset while a result for rd 7 is buffered.
    step(1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'h77);
    @(negedge CLK);
    check_out();
    PIPE_VALID = 1'b0;
    LU_VALID   = 1'b0;
    RST_N      = 1'b0;
    #1;
    check_eq("mid_rst_rf_we", RF_WRITE_EN, 1'b0);
    check_eq("mid_rst_rf_add", RF_WRITE_ADD, '0);
    check_eq("mid_rst_rf_data", RF_WRITE_DATA, '0);
    check_eq("mid_rst_wb_sel", WB_SELECT, 1'b0);
    check_eq("mid_rst_busy", BUSY, 1'b0);
    check_eq("mid_rst_stall", PIPE_STALL, 1'b0);
    check_eq("mid_rst_lu_ready", LU_READY, 1'b1);
    model_reset();
    exp_chk = 1'b1;
    #2;
    RST_N = 1'b1;
    idle(3);

    // Randomized traffic honouring the hold-while-not-accepted rules of both producers.
    for (int i = 0; i < 600; i++) begin
      bit            pv, lv;
      logic [AW-1:0] prd, lrd;
      logic [DW-1:0] pd, ld;
      pv  = ($urandom_range(0, 9) < 6);
      prd = AW'($urandom_range(0, 7));
      pd  = $urandom;
      lv  = ($urandom_range(0, 9) < 4);
      lrd = AW'($urandom_range(0, 7));
      ld  = $urandom;
      if (pipe_hold) begin
        pv = s_pv; prd = s_prd; pd = s_pd;
      end
      if (lu_hold) begin
        lv = s_lv; lrd = s_lrd; ld = s_ld;
      end
      step(pv, prd, pd, lv, lrd, ld);
    end
    idle(3);
    @(negedge CLK);
    check_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two producers:
  - the in-order pipeline write-back stream (ALU/load results), and
  - the long-latency unit (multiply/divide) result stream.
- Holds one long-latency result in a one-entry buffer.
- Gives the pipeline priority, with a starvation limit on that priority.
- Drives the write-back 2:1 mux select and the registered register-file write signals.

Parameters:
- DATA_WIDTH, 32, width of result data.
- REG_ADD_WIDTH, 5, width of destination register address.
- STARVE_LIMIT, 4, consecutive cycles a buffered long-latency result may lose arbitration before it is forced; legal range 1..15.

Ports:
- CLK  input  1  clock, all state on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- PIPE_VALID  input  1  pipeline presents a write-back this cycle.
- PIPE_RD  input  REG_ADD_WIDTH  pipeline destination register.
- PIPE_DATA  input  DATA_WIDTH  pipeline result.
- PIPE_STALL  output  1  pipeline write not accepted; pipeline must hold its inputs.
- LU_VALID  input  1  long-latency unit presents a result.
- LU_RD  input  REG_ADD_WIDTH  long-latency destination register.
- LU_DATA  input  DATA_WIDTH  long-latency result.
- LU_READY  output  1  long-latency result accepted this cycle when LU_VALID=1.
- WB_SELECT  output  1  0 = pipeline source, 1 = long-latency source; registered, aligned with the RF_* outputs.
- RF_WRITE_EN  output  1  register-file write enable, registered.
- RF_WRITE_ADD  output  REG_ADD_WIDTH  register-file write address, registered.
- RF_WRITE_DATA  output  DATA_WIDTH  register-file write data, registered.
- BUSY  output  1  buffer occupied (state != IDLE).

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state=IDLE, buffer invalid, starve counter=0.
  - RF_WRITE_EN=0, RF_WRITE_ADD=0, RF_WRITE_DATA=0, WB_SELECT=0, BUSY=0.
  - PIPE_STALL=0; LU_READY=1 once the combinational logic settles in IDLE.
  - Reset mid-operation discards any buffered result without writing it.
- Grant rules:
  - At most one write per cycle.
  - The grant is decided combinationally from the current state and inputs.
  - The granted write appears on RF_*/WB_SELECT on the next cycle (1-cycle latency).
  - When no write is granted, RF_WRITE_EN=0 next cycle; RF_WRITE_ADD/RF_WRITE_DATA hold their previous values.
- Handshakes:
  - Pipeline write accepted when PIPE_VALID && !PIPE_STALL.
  - PIPE_STALL = (state==FORCE) && PIPE_VALID, combinational.
  - LU result accepted when LU_VALID && LU_READY.
  - LU_READY = (state==IDLE), combinational.
- Register x0: a granted write with rd=0 is consumed normally but produces RF_WRITE_EN=0.
- IDLE:
  - PIPE_VALID=1: grant pipeline. If LU_VALID is also 1, capture the LU result into the buffer, counter=0, go to PENDING.
  - PIPE_VALID=0 and LU_VALID=1: grant LU directly (bypass), buffer stays empty, stay IDLE.
  - Neither valid: stay IDLE.
- PENDING:
  - PIPE_VALID=0: drain the buffer (grant buffer, WB_SELECT=1), go to IDLE, counter=0.
  - PIPE_VALID=1: grant pipeline and increment the counter. When the counter reaches STARVE_LIMIT, go to FORCE.
- FORCE:
  - Drain the buffer unconditionally; pipeline is stalled when valid.
  - Go to IDLE, counter=0.
- Same-register kill:
  - A buffered result is always older in program order than any pipeline write accepted while it is buffered.
  - If an accepted pipeline write has PIPE_RD == buffered rd and rd != 0, the buffer is invalidated, state goes to IDLE and counter=0.
  - The pipeline write proceeds normally.
  - The kill applies in PENDING. It also applies in IDLE on the capture cycle, where the LU result is then discarded and not captured.
- Counter: saturates, never wraps; it is 4 bits wide, which is sufficient for STARVE_LIMIT ≤ 15.

Test Plan:
- Reset with RST_N low mid-PENDING (buffer rd=7) -> all outputs 0 asynchronously; after release, LU_READY=1 and rd 7 is never written.
- PIPE idle, LU_VALID with rd=3 / 0xDEADBEEF -> next cycle RF_WRITE_EN=1, ADD=3, DATA=0xDEADBEEF, WB_SELECT=1; LU_READY stays 1.
- Simultaneous PIPE (rd=1, 0x11) and LU (rd=2, 0x22), then PIPE idle -> cycle+1 writes rd1/WB_SELECT=0; cycle+2 writes rd2/WB_SELECT=1; LU_READY low during PENDING only.
- LU buffered, then PIPE_VALID continuous with STARVE_LIMIT=4 -> 1 pipeline write on the capture cycle plus 4 pipeline writes in PENDING, then PIPE_STALL=1 for one cycle and the buffered result is written; the stalled pipeline write is accepted the following cycle.
- Buffered rd=5 (0xAA), pipeline writes rd=5 (0xBB) -> only 0xBB is written to rd5, BUSY drops, no WB_SELECT=1 write occurs.
- LU rd=0 via bypass, and pipeline rd=0 -> consumed (handshakes complete), RF_WRITE_EN stays 0.
